mult_div_unit: RTL

Multi-cycle signed multiply/divide unit. It sits beside the pipeline ALU and executes the Mult (ALU_Control 4'b0101) and Div (4'b1011) codes produced by the ALU control decoder. Results go into architectural Hi/Lo registers. Busy stalls the pipeline while an operation is in flight.

---
 rtl/mult_div_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit writing architectural Hi/Lo.
// A shared 2W+1 bit accumulator runs radix-2 shift-add (mult) or restoring division (div).
//
// state | meaning
// IDLE  | waiting for a valid Start
// ITER  | one shift-add / restoring step per cycle, WIDTH steps
// FIX   | apply result signs, write Hi/Lo
// DONE  | Done pulse; may accept a back-to-back Start
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH:0]     acc;
  logic [WIDTH-1:0]     operand;
  logic                 is_div;
  logic                 neg_lo;
  logic                 neg_hi;

  logic                 op_mult, op_div, accept;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH:0]     step_next;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign op_mult = (ALU_Control == OP_MULT);
  assign op_div  = (ALU_Control == OP_DIV);
  assign accept  = Start && (op_mult || op_div) && (state == IDLE || state == DONE);

  // Magnitude of the most-negative value is the unsigned 2^(W-1), which fits in W bits.
  assign mag_a = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign mag_b = B[WIDTH-1] ? (~B + 1'b1) : B;

  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
    rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff      = rem_sh - {1'b0, operand};
    step_next = '0;
    if (is_div) begin
      if (diff[WIDTH]) step_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
      else             step_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      step_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_s = neg_lo ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];
    quo_s  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_s  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    fix_hi = is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? quo_s : prod_s[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            is_div    <= op_div;
            neg_lo    <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_hi    <= A[WIDTH-1];
            acc       <= {{(WIDTH+1){1'b0}}, (op_div ? mag_a : mag_b)};
            operand   <= op_div ? mag_b : mag_a;
            cnt       <= '0;
            DivByZero <= 1'b0;
            if (op_div && (B == '0)) begin
              Hi        <= A;
              Lo        <= '1;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= DONE;
            end else begin
              Busy  <= 1'b1;
              state <= ITER;
            end
          end
        end
        ITER: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          Hi    <= fix_hi;
          Lo    <= fix_lo;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
